mem_port_arbiter: RTL and testbench

- Shares the single core memory port between the instruction requester (prefetch path) and the data requester (load/store path).
- Arbitrates between the two, registers the winning request, and holds it on the memory port until mem_ready.
- Routes the response back to the winner.
- Bounded data priority with instruction anti-starvation; supports dropping an in-flight instruction fetch on a redirect.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single core memory port between the
// instruction (prefetch) requester and the data (load/store) requester.
// Data wins ties for up to MAX_DBURST consecutive grants while an
// instruction request waits; then the instruction is served.
// Optional macro MEM_PORT_ARB_B2B_EN: re-arbitrate in the completion cycle
// so a pending request from the other requester follows with no bubble.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DBURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_ready,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_valid,
    output logic                mem_instr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int         STRB_W     = DATA_W / 8;
    localparam logic [3:0] DBURST_LIM = 4'(MAX_DBURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wstrb;
    logic                req_instr;
    logic                drop;
    logic [3:0]          dcnt;
    logic                mem_valid_q;

    logic                arb_en;
    logic                cand_i;
    logic                cand_d;
    logic                grant_i;
    logic                grant_d;
    logic [3:0]          dcnt_next;

    // Select which requests compete this cycle and pick the winner.
    // In a completion cycle (B2B build) the completing requester is excluded,
    // so its still-high valid neither competes nor counts as a waiting
    // instruction for the burst counter.
    always_comb begin
        arb_en = 1'b0;
        cand_i = 1'b0;
        cand_d = 1'b0;
        case (state)
            IDLE: begin
                arb_en = 1'b1;
                cand_i = i_valid;
                cand_d = d_valid;
            end
`ifdef MEM_PORT_ARB_B2B_EN
            IBUSY: begin
                arb_en = mem_ready;
                cand_d = d_valid;
            end
            DBUSY: begin
                arb_en = mem_ready;
                cand_i = i_valid;
            end
`endif
            default: begin
                arb_en = 1'b0;
            end
        endcase

        grant_d = arb_en & cand_d & (~cand_i | (dcnt != DBURST_LIM));
        grant_i = arb_en & cand_i & ~grant_d;

        if (grant_i) begin
            dcnt_next = 4'd0;
        end else if (grant_d) begin
            if (!cand_i)
                dcnt_next = 4'd0;
            else if (dcnt == DBURST_LIM)
                dcnt_next = dcnt;
            else
                dcnt_next = dcnt + 4'd1;
        end else begin
            dcnt_next = dcnt;
        end
    end

    // Arbiter FSM: latches the winning request and holds it on the port
    // until mem_ready; mem_valid is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            drop        <= 1'b0;
            dcnt        <= 4'd0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_wstrb   <= '0;
            req_instr   <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            dcnt <= dcnt_next;
            if (grant_i) begin
                req_addr    <= i_addr;
                req_wdata   <= '0;
                req_wstrb   <= '0;
                req_instr   <= 1'b1;
                drop        <= 1'b0;
                state       <= IBUSY;
                mem_valid_q <= 1'b1;
            end else if (grant_d) begin
                req_addr    <= d_addr;
                req_wdata   <= d_wdata;
                req_wstrb   <= d_wstrb;
                req_instr   <= 1'b0;
                drop        <= 1'b0;
                state       <= DBUSY;
                mem_valid_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        mem_valid_q <= 1'b0;
                    end
                    IBUSY: begin
                        if (mem_ready) begin
                            state       <= IDLE;
                            drop        <= 1'b0;
                            mem_valid_q <= 1'b0;
                        end else if (i_flush) begin
                            drop <= 1'b1;
                        end
                    end
                    DBUSY: begin
                        if (mem_ready) begin
                            state       <= IDLE;
                            mem_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        drop        <= 1'b0;
                        mem_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Memory port is driven only from the latched request.
    assign mem_valid = mem_valid_q;
    assign mem_instr = req_instr;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign mem_wstrb = req_wstrb;

    // Response routing: a flushed or dropped fetch never sees i_ready.
    assign i_ready = (state == IBUSY) & mem_ready & ~drop & ~i_flush;
    assign d_ready = (state == DBUSY) & mem_ready;
    assign i_rdata = i_ready ? mem_rdata : '0;
    assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction scoreboard.
// Build with +define+MEM_PORT_ARB_B2B_EN to exercise the back-to-back mode.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DBURST(4)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_flush(i_flush),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        ready;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata, input logic ready);
        exp_t e;
        e.instr = instr; e.addr = addr; e.wdata = wdata;
        e.wstrb = wstrb; e.rdata = rdata; e.ready = ready;
        sb.push_back(e);
    endtask

    // Wait for the next memory request, answer it after wait_cyc cycles and
    // check it against the scoreboard head. flush_mode 1 pulses i_flush the
    // cycle before mem_ready, 2 raises it in the mem_ready cycle.
    task automatic serve(input int wait_cyc, input int exp_lat, input int flush_mode,
                         input bit exp_bubble);
        exp_t e;
        int   n;
        n = 0;
        while (!mem_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("mem_valid_up", mem_valid, 1'b1);
        if (exp_lat >= 0) chk32("grant_latency", 32'(n), 32'(exp_lat));
        chk1("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int j = 0; j < wait_cyc; j++) begin
            if (flush_mode == 1 && j == wait_cyc - 1) begin
                i_flush = 1'b1;
                i_valid = 1'b0;
                i_addr  = 32'hFFFF_FFFC;
            end
            #1;
            chk1("i_ready_wait", i_ready, 1'b0);
            chk1("d_ready_wait", d_ready, 1'b0);
            chk32("mem_addr_hold", mem_addr, e.addr);
            @(negedge clk);
            i_flush = 1'b0;
        end
        if (flush_mode == 2) i_flush = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = e.rdata;
        #1;
        chk1("mem_instr", mem_instr, e.instr);
        chk32("mem_addr", mem_addr, e.addr);
        chk32("mem_wdata", mem_wdata, e.wdata);
        chk32("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        chk1("i_ready", i_ready, e.instr & e.ready);
        chk1("d_ready", d_ready, ~e.instr);
        chk32("i_rdata", i_rdata, (e.instr & e.ready) ? e.rdata : 32'h0);
        chk32("d_rdata", d_rdata, e.instr ? 32'h0 : e.rdata);
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        i_flush   = 1'b0;
        #1;
        chk1("i_ready_pulse", i_ready, 1'b0);
        chk1("d_ready_pulse", d_ready, 1'b0);
        if (exp_bubble) chk1("idle_bubble", mem_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #7;
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk1("rst_mem_instr", mem_instr, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk32("rst_i_rdata", i_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single instruction read with two wait cycles
        i_valid = 1'b1; i_addr = 32'h100;
        push(1'b1, 32'h100, 32'h0, 4'h0, 32'h0000_0013, 1'b1);
        serve(2, 1, 0, 1'b1);
        i_valid = 1'b0;

        // simultaneous requests: data first, then instruction
        i_valid = 1'b1; i_addr = 32'h200;
        d_valid = 1'b1; d_addr = 32'h8000_0000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        push(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b1);
        push(1'b1, 32'h200, 32'h0, 4'h0, 32'h0000_0093, 1'b1);
`ifdef MEM_PORT_ARB_B2B_EN
        serve(1, 1, 0, 1'b0);
        chk1("b2b_mem_valid", mem_valid, 1'b1);
        chk32("b2b_mem_addr", mem_addr, 32'h200);
        d_valid = 1'b0;
        serve(0, 0, 0, 1'b1);
        i_valid = 1'b0;
`else
        serve(1, 1, 0, 1'b1);
        d_valid = 1'b0;
        serve(0, 1, 0, 1'b1);
        i_valid = 1'b0;

        // starvation: six stores against a held fetch, order D,D,D,D,I,D,D
        i_valid = 1'b1; i_addr = 32'h500;
        d_valid = 1'b1; d_addr = 32'h1000; d_wdata = 32'hA0; d_wstrb = 4'hF;
        for (int k = 0; k < 4; k++)
            push(1'b0, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF, 32'h5A5A_0000 + 32'(k), 1'b1);
        push(1'b1, 32'h500, 32'h0, 4'h0, 32'h0000_0513, 1'b1);
        for (int k = 4; k < 6; k++)
            push(1'b0, 32'h1000 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF, 32'h5A5A_0000 + 32'(k), 1'b1);
        begin
            int k;
            k = 0;
            for (int t = 0; t < 7; t++) begin
                serve(0, 1, 0, 1'b1);
                if (t == 4) begin
                    i_valid = 1'b0;
                end else begin
                    k++;
                    if (k < 6) begin
                        d_addr  = 32'h1000 + 32'(4 * k);
                        d_wdata = 32'hA0 + 32'(k);
                    end else begin
                        d_valid = 1'b0;
                    end
                end
            end
        end
`endif

        // flush the cycle before mem_ready, then a fresh fetch is accepted
        i_valid = 1'b1; i_addr = 32'h300;
        push(1'b1, 32'h300, 32'h0, 4'h0, 32'hBAD0_0300, 1'b0);
        serve(2, 1, 1, 1'b1);
        i_valid = 1'b1; i_addr = 32'h400;
        push(1'b1, 32'h400, 32'h0, 4'h0, 32'h0000_0413, 1'b1);
        serve(0, 1, 0, 1'b1);
        i_valid = 1'b0;

        // flush in the mem_ready cycle suppresses i_ready
        i_valid = 1'b1; i_addr = 32'h600;
        push(1'b1, 32'h600, 32'h0, 4'h0, 32'h0000_0613, 1'b0);
        serve(1, 1, 2, 1'b1);
        i_valid = 1'b0;

        // asynchronous reset in the middle of a data transaction
        d_valid = 1'b1; d_addr = 32'h9000; d_wdata = 32'h0BAD_F00D; d_wstrb = 4'h3;
        @(negedge clk);
        d_valid = 1'b0;
        chk1("pre_rst_mem_valid", mem_valid, 1'b1);
        chk32("pre_rst_mem_addr", mem_addr, 32'h9000);
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk1("pre_rst_d_ready", d_ready, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk1("async_rst_mem_valid", mem_valid, 1'b0);
        chk1("async_rst_d_ready", d_ready, 1'b0);
        chk32("async_rst_d_rdata", d_rdata, 32'h0);
        chk32("async_rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk1("post_rst_mem_valid", mem_valid, 1'b0);
            chk1("post_rst_d_ready", d_ready, 1'b0);
        end

        chk32("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
